// File: rtl/fuzz_run_sequencer_if.sv
// Run-control and DUT-facing signal bundle for fuzz_run_sequencer.
// The sequencer connects through the seq modport; the host/harness uses ctrl.
interface fuzz_run_sequencer_if #(
  parameter int unsigned Y_W   = 867,
  parameter int unsigned SIG_W = 32
);
  logic             start;
  logic [63:0]      seed;
  logic [15:0]      run_len;
  logic [13:0]      stim_wire0;
  logic [15:0]      stim_wire1;
  logic [16:0]      stim_wire2;
  logic [2:0]       stim_wire3;
  logic [Y_W-1:0]   dut_y;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic [15:0]      cycle_count;

  modport ctrl (
    output start, seed, run_len, dut_y,
    input  stim_wire0, stim_wire1, stim_wire2, stim_wire3,
    input  busy, done, signature, cycle_count
  );

  modport seq (
    input  start, seed, run_len, dut_y,
    output stim_wire0, stim_wire1, stim_wire2, stim_wire3,
    output busy, done, signature, cycle_count
  );
endinterface

// File: rtl/fuzz_run_sequencer.sv
// Drives a DUT from a seeded 64-bit Galois LFSR and compresses its output bus
// into a MISR signature; one run per accepted start.
module fuzz_run_sequencer #(
  parameter int unsigned     Y_W          = 867,
  parameter int unsigned     SIG_W        = 32,
  parameter logic [SIG_W-1:0] SIG_POLY    = 32'h04C11DB7,
  parameter int unsigned     DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fuzz_run_sequencer_if.seq  bus
);

  localparam int unsigned N_CHUNK = (Y_W + SIG_W - 1) / SIG_W;
  localparam int unsigned PAD_W   = N_CHUNK * SIG_W;
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        lfsr_q, lfsr_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        len_q, len_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [PAD_W-1:0]   y_pad;
  logic [SIG_W-1:0]   fold;
  logic [SIG_W-1:0]   sig_step;
  logic [63:0]        lfsr_step;
  logic [15:0]        cnt_inc;

  // XOR-fold the zero-padded output bus down to one signature-wide word
  assign y_pad = PAD_W'(bus.dut_y);

  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < N_CHUNK; i++) begin
      fold = fold ^ y_pad[i*SIG_W +: SIG_W];
    end
  end

  assign sig_step  = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? SIG_POLY : '0) ^ fold;
  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 64'h0);
  assign cnt_inc   = 16'(cnt_q + 16'd1);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    drain_d = drain_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // An all-zero seed would lock the LFSR, so substitute 1
          lfsr_d  = (bus.seed == 64'h0) ? 64'h1 : bus.seed;
          len_d   = bus.run_len;
          sig_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        drain_d = '0;
        state_d = (len_q != 16'd0) ? S_RUN : S_DRAIN;
      end
      S_RUN: begin
        sig_d  = sig_step;
        lfsr_d = lfsr_step;
        cnt_d  = cnt_inc;
        if (cnt_inc == len_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        sig_d   = sig_step;
        drain_d = DRAIN_W'(drain_q + DRAIN_W'(1));
        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.stim_wire0  = lfsr_q[13:0];
  assign bus.stim_wire1  = lfsr_q[29:14];
  assign bus.stim_wire2  = lfsr_q[46:30];
  assign bus.stim_wire3  = lfsr_q[49:47];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.signature   = sig_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: doc/fuzz_run_sequencer.md
Name: fuzz_run_sequencer

Overview:
- Sequences one fuzz-test run of a generated combinational/sequential DUT.
- Drives the DUT's four data inputs from a seeded 64-bit LFSR for a programmable number of cycles, then waits for pipeline drain.
- Compresses the DUT's wide output bus into a MISR signature every capture cycle.
- Sits between the run-control host (start/seed/length) and the DUT; simulator-vs-simulator signature mismatches flag tool bugs.

Parameters:
- Y_W, 867, width of DUT output bus y.
- SIG_W, 32, MISR signature width.
- SIG_POLY, 32'h04C11DB7, MISR feedback polynomial (taps applied when shifting out a 1).
- DRAIN_CYCLES, 4, capture cycles after stimulus stops; must be >= 1.

Ports:
- clk  input  1  single clock; also the DUT clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE.
- seed  input  64  LFSR seed, latched on accepted start.
- run_len  input  16  stimulus cycles; 0 means skip RUN.
- stim_wire0  output  14  DUT wire0 = lfsr[13:0].
- stim_wire1  output  16  DUT wire1 = lfsr[29:14].
- stim_wire2  output  17  DUT wire2 = lfsr[46:30].
- stim_wire3  output  3  DUT wire3 = lfsr[49:47].
- dut_y  input  Y_W  DUT output bus.
- busy  output  1  high from accepted start until done pulses.
- done  output  1  one-cycle pulse when signature is final.
- signature  output  SIG_W  MISR value; stable from done until next accepted start.
- cycle_count  output  16  stimulus cycles issued in the current/last run.

Behaviour:
- Reset (async assert, sync release): state=IDLE, lfsr=0, sig=0, counters=0, busy=0, done=0. All stim outputs are 0.
- States: IDLE, LOAD, RUN, DRAIN, FINISH.
- IDLE: start=1 -> latch seed (seed==0 replaced by 64'h1), latch run_len, clear sig and cycle_count, go to LOAD. busy rises the same edge.
- LOAD: one cycle. Stim outputs show the seed value. Go to RUN if run_len!=0, else DRAIN.
- RUN: each cycle capture dut_y into MISR, advance LFSR, increment cycle_count. Leave for DRAIN on the edge where cycle_count reaches run_len.
- LFSR step (Galois, right shift): next = (lfsr>>1) ^ (lfsr[0] ? 64'hD800000000000000 : 0).
- DRAIN: LFSR frozen. Capture dut_y into MISR for exactly DRAIN_CYCLES cycles, then go to FINISH.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Fold: zero-pad dut_y to a multiple of SIG_W, then XOR all SIG_W-wide chunks together.
- MISR step: sig_next = (sig<<1) ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ fold. Arithmetic is mod 2^SIG_W.
- Capture count = run_len + DRAIN_CYCLES; LOAD does not capture.
- start while busy: ignored, with no effect on state or latched values.
- start on the same edge as FINISH: ignored; it must be reasserted in IDLE.
- rst_n low mid-run: immediate abort to reset values. No done pulse. Signature is lost.
- cycle_count saturates at run_len and holds after the run until the next accepted start.

Test Plan:
- Reset, seed=64'h1, run_len=1, dut_y=0 -> LOAD shows stim_wire0=14'h1 and the other stims 0. The first RUN step gives lfsr=64'hD800000000000000, so all stim outputs read 0. done pulses 1+1+4+1 cycles after start; signature=0.
- dut_y=0 constant, seed=64'h0, run_len=3 -> the seed is replaced by 1. Stim sequence follows the LFSR from 1. signature=32'h0, cycle_count=3.
- dut_y with only bit0=1 constant, run_len=0 -> 4 DRAIN captures give sig=1, 3, 7, 15 in sequence. Final signature=32'h0000000F.
- start pulsed again during RUN with a different seed -> no restart. Signature equals that of the undisturbed run.
- rst_n dropped for 1 cycle in RUN -> busy=0 and signature=0 immediately, with no done. A subsequent identical run reproduces the golden signature.
- Back-to-back runs with the same seed/run_len and random dut_y replayed identically -> identical signatures. Changing one dut_y bit in one capture cycle changes the signature.
